// File: rtl/xdble_drain_pkg.sv
// Shared types and constants for the xDBLe result drain: FSM states, stream
// source encodings and the bit positions of the read / copy-back enables.
package xdble_drain_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    // m_sel encodings, also the read order of the result memories
    localparam logic [1:0] SEL_T6_0 = 2'd0;
    localparam logic [1:0] SEL_T6_1 = 2'd1;
    localparam logic [1:0] SEL_T7_0 = 2'd2;
    localparam logic [1:0] SEL_T7_1 = 2'd3;

    localparam int RD_T6_0 = 0;
    localparam int RD_T6_1 = 1;
    localparam int RD_T7_0 = 2;
    localparam int RD_T7_1 = 3;

    localparam int CB_X_0 = 0;
    localparam int CB_X_1 = 1;
    localparam int CB_Z_0 = 2;
    localparam int CB_Z_1 = 3;

    // Output head plus two skid entries: covers the two-cycle issue-to-land loop.
    localparam int SKID_SLOTS = 3;

    function automatic logic [3:0] rd_onehot(input logic [1:0] sel);
        logic [3:0] v;
        v = '0;
        case (sel)
            SEL_T6_0: v[RD_T6_0] = 1'b1;
            SEL_T6_1: v[RD_T6_1] = 1'b1;
            SEL_T7_0: v[RD_T7_0] = 1'b1;
            default:  v[RD_T7_1] = 1'b1;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] cb_onehot(input logic [1:0] sel);
        logic [3:0] v;
        v = '0;
        case (sel)
            SEL_T6_0: v[CB_X_0] = 1'b1;
            SEL_T6_1: v[CB_X_1] = 1'b1;
            SEL_T7_0: v[CB_Z_0] = 1'b1;
            default:  v[CB_Z_1] = 1'b1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// Small valid/ready buffer for the drain stream: slot 0 is the output head,
// the remaining slots absorb words still returning from the memories.
module drain_skid_buf
    import xdble_drain_pkg::*;
#(
    parameter int DW = 35
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic [1:0]    occ
);

    logic [DW-1:0] slot     [SKID_SLOTS];
    logic [DW-1:0] slot_nxt [SKID_SLOTS];
    logic [1:0]    cnt;

    // NOTE: slot_nxt starts as a full copy of slot, so every path assigns it and no latch is inferred.
    always_comb begin
        slot_nxt = slot;
        if (pop) begin
            for (int i = 0; i < SKID_SLOTS - 1; i++) begin
                slot_nxt[i] = slot[i + 1];
            end
        end
        if (push) begin
            slot_nxt[cnt - 2'(pop)] = din;
        end
    end

    // NOTE: the storage is reset because slot 0 drives the stream outputs, which must read 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SKID_SLOTS; i++) begin
                slot[i] <= '0;
            end
            cnt <= '0;
        end else begin
            slot <= slot_nxt;
            cnt  <= cnt + 2'(push) - 2'(pop);
        end
    end

    assign dout  = slot[0];
    assign valid = (cnt != 2'd0);
    assign occ   = cnt;

endmodule

// File: rtl/xdble_result_drain.sv
// Drains t6_0, t6_1, t7_0, t7_1 word by word into a valid/ready stream.
// Define XDBLE_DRAIN_COPYBACK_EN to also write each returned word into X/Z.
module xdble_result_drain
    import xdble_drain_pkg::*;
#(
    parameter int RADIX      = 32,
    parameter int WIDTH_REAL = 14,
    // Kept at least 1 bit wide so WIDTH_REAL=1 still has a legal address bus.
    parameter int DEPTH_LOG  = (WIDTH_REAL > 1) ? $clog2(WIDTH_REAL) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           rd_en,
    output logic [DEPTH_LOG-1:0] rd_addr,
    input  logic [4*RADIX-1:0]   rd_dout,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [RADIX-1:0]     m_data,
    output logic [1:0]           m_sel,
    output logic                 m_last,
    output logic [3:0]           cb_wr_en,
    output logic [DEPTH_LOG-1:0] cb_wr_addr,
    output logic [RADIX-1:0]     cb_din
);

    localparam logic [DEPTH_LOG-1:0] ADDR_LAST = DEPTH_LOG'(WIDTH_REAL - 1);
    localparam int                   BW        = RADIX + 3;

    state_t               state;
    logic [1:0]           sel_cnt;
    logic [DEPTH_LOG-1:0] addr_cnt;
    logic [1:0]           rd_sel;
    logic                 rd_last;
    logic                 ret_valid;
    logic [1:0]           ret_sel;
    logic                 ret_last;
    logic [RADIX-1:0]     ret_word;
    logic                 rd_active;
    logic                 pop;
    logic                 is_last;
    logic                 space_ok;
    logic                 issue;
    logic [2:0]           fill_next;
    logic [1:0]           occ;
    logic [BW-1:0]        buf_dout;

    assign rd_active = |rd_en;
    assign pop       = m_valid & m_ready;
    assign ret_word  = rd_dout[int'(ret_sel) * RADIX +: RADIX];
    assign is_last   = (sel_cnt == SEL_T7_1) && (addr_cnt == ADDR_LAST);

    // Slots claimed after this edge: buffered words plus both read stages, less the word leaving now.
    always_comb begin
        fill_next = 3'(occ) + 3'(ret_valid) + 3'(rd_active) - 3'(pop);
        space_ok  = fill_next < 3'(SKID_SLOTS);
        issue     = ((state == S_IDLE) && start) || ((state == S_RUN) && space_ok);
    end

    // NOTE: all state here uses <= so every register samples pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            sel_cnt   <= '0;
            addr_cnt  <= '0;
            rd_en     <= '0;
            rd_addr   <= '0;
            rd_sel    <= '0;
            rd_last   <= 1'b0;
            ret_valid <= 1'b0;
            ret_sel   <= '0;
            ret_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_en     <= issue ? rd_onehot(sel_cnt) : 4'b0000;
            ret_valid <= rd_active;
            ret_sel   <= rd_sel;
            ret_last  <= rd_last;
            done      <= 1'b0;

            if (issue) begin
                rd_addr <= addr_cnt;
                rd_sel  <= sel_cnt;
                rd_last <= is_last;
                if (addr_cnt == ADDR_LAST) begin
                    addr_cnt <= '0;
                    sel_cnt  <= sel_cnt + 2'd1;
                end else begin
                    addr_cnt <= addr_cnt + 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (issue && is_last) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (pop && m_last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    drain_skid_buf #(
        .DW (BW)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (ret_valid),
        .din   ({ret_last, ret_sel, ret_word}),
        .pop   (pop),
        .dout  (buf_dout),
        .valid (m_valid),
        .occ   (occ)
    );

    assign m_data = buf_dout[RADIX-1:0];
    assign m_sel  = buf_dout[RADIX +: 2];
    assign m_last = buf_dout[BW-1];

`ifdef XDBLE_DRAIN_COPYBACK_EN
    logic [DEPTH_LOG-1:0] ret_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ret_addr <= '0;
        end else begin
            ret_addr <= rd_addr;
        end
    end

    // Written as the word returns, independent of stream backpressure.
    assign cb_wr_en   = ret_valid ? cb_onehot(ret_sel) : 4'b0000;
    assign cb_wr_addr = ret_valid ? ret_addr : '0;
    assign cb_din     = ret_valid ? ret_word : '0;
`else
    assign cb_wr_en   = '0;
    assign cb_wr_addr = '0;
    assign cb_din     = '0;
`endif

endmodule

// File: tb/tb_xdble_result_drain.sv
// Scoreboard bench for xdble_result_drain: expected beats are queued at start,
// a negedge monitor pops and compares every accepted beat.
module tb_xdble_result_drain;

    localparam int RADIX = 32;
    localparam int W     = 14;
    localparam int AW    = 4;
    localparam int BEATS = 4 * W;

    typedef struct packed {
        logic        last;
        logic [1:0]  sel;
        logic [31:0] data;
    } beat_t;

    logic               clk;
    logic               rst;
    logic               start;
    logic               busy;
    logic               done;
    logic [3:0]         rd_en;
    logic [AW-1:0]      rd_addr;
    logic [4*RADIX-1:0] rd_dout;
    logic               m_valid;
    logic               m_ready;
    logic [RADIX-1:0]   m_data;
    logic [1:0]         m_sel;
    logic               m_last;
    logic [3:0]         cb_wr_en;
    logic [AW-1:0]      cb_wr_addr;
    logic [RADIX-1:0]   cb_din;

    logic               start1;
    logic               busy1;
    logic               done1;
    logic [3:0]         rd_en1;
    logic [0:0]         rd_addr1;
    logic [4*RADIX-1:0] rd_dout1;
    logic               m_valid1;
    logic               m_ready1;
    logic [RADIX-1:0]   m_data1;
    logic [1:0]         m_sel1;
    logic               m_last1;
    logic [3:0]         cb_wr_en1;
    logic [0:0]         cb_wr_addr1;
    logic [RADIX-1:0]   cb_din1;

    beat_t       exp_q[$];
    int          n_cmp;
    int          n_fail;
    int          beats;
    int          cb_pulses;
    int          stall_reads;
    logic [31:0] xz [4][W];
    logic        hold_v;
    beat_t       hold_b;

    xdble_result_drain #(.RADIX(RADIX), .WIDTH_REAL(W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(rd_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sel(m_sel), .m_last(m_last),
        .cb_wr_en(cb_wr_en), .cb_wr_addr(cb_wr_addr), .cb_din(cb_din)
    );

    xdble_result_drain #(.RADIX(RADIX), .WIDTH_REAL(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_dout(rd_dout1),
        .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .m_sel(m_sel1), .m_last(m_last1),
        .cb_wr_en(cb_wr_en1), .cb_wr_addr(cb_wr_addr1), .cb_din(cb_din1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input int sel, input int addr);
        return (32'(sel) << 16) | 32'(addr);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result memories: one-cycle synchronous read, poison when not read.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            rd_dout[i*RADIX +: RADIX]  <= (rd_en[i] && int'(rd_addr) < W) ? mem_word(i, int'(rd_addr)) : 32'hDEAD_BEEF;
            rd_dout1[i*RADIX +: RADIX] <= (rd_en1[i] && rd_addr1 == 1'b0) ? mem_word(i, 0) : 32'hDEAD_BEEF;
        end
    end

    // Monitor for the main instance.
    always @(negedge clk) begin
        if (!rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 64'(m_valid), 64'(1));
                check("hold_beat", 64'({m_last, m_sel, m_data}), 64'(hold_b));
            end
            if (|rd_en) begin
                check("rd_en_onehot", 64'($countones(rd_en)), 64'(1));
                if (!m_ready) stall_reads++;
            end
            if (cb_wr_en != 4'b0000) begin
                cb_pulses++;
                check("cb_onehot", 64'($countones(cb_wr_en)), 64'(1));
                for (int i = 0; i < 4; i++) begin
                    if (cb_wr_en[i] && int'(cb_wr_addr) < W) xz[i][cb_wr_addr] = cb_din;
                end
            end
            if (m_valid && m_ready) begin
                check("sb_has_entry", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat", 64'({m_last, m_sel, m_data}), 64'(e));
                end
                beats++;
            end
            hold_v = m_valid && !m_ready;
            hold_b = {m_last, m_sel, m_data};
        end
    end

    task automatic check_all_zero(input string name);
        check(name, 64'({busy, done, rd_en, rd_addr, m_valid, m_sel, m_last, cb_wr_en, cb_wr_addr}), 64'(0));
        check({name, "_data"}, 64'({m_data, cb_din}), 64'(0));
    endtask

    // mode 0: ready held; 1: stall 10 cycles at beat 5; 2: random ready;
    // 3: extra start at beat 20 and during DONE; 4: reset at beat 30.
    task automatic drain(input int mode, output int lat);
        bit got_done;
        bit restarted;
        bit aborted;
        int stall_left;
        bit stall_started;
        exp_q.delete();
        for (int s = 0; s < 4; s++) begin
            for (int a = 0; a < W; a++) begin
                exp_q.push_back({(s == 3 && a == W - 1), 2'(s), mem_word(s, a)});
                xz[s][a] = '0;
            end
        end
        beats = 0; cb_pulses = 0; stall_reads = 0;
        lat = 0; got_done = 0; restarted = 0; aborted = 0; stall_left = 0; stall_started = 0;
        @(posedge clk); #1;
        m_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (k == 1) check("busy_c1", 64'(busy), 64'(1));
            if (done) begin
                lat = k;
                got_done = 1;
                check("busy_at_done", 64'(busy), 64'(0));
                break;
            end
            @(posedge clk); #1;
            case (mode)
                1: begin
                    if (beats >= 5 && !stall_started) begin
                        stall_started = 1;
                        stall_left = 10;
                    end
                    if (stall_left > 0) begin
                        m_ready = 1'b0;
                        stall_left--;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
                2: m_ready = 1'($urandom_range(0, 1));
                3: begin
                    start = 1'b0;
                    if (beats >= 20 && !restarted) begin
                        start = 1'b1;
                        restarted = 1;
                    end
                end
                4: begin
                    if (beats >= 30) begin
                        rst = 1'b0;
                        #1;
                        check_all_zero("reset_mid_drain");
                        aborted = 1;
                        break;
                    end
                end
                default: m_ready = 1'b1;
            endcase
        end
        if (!aborted) begin
            check("done_seen", 64'(got_done), 64'(1));
            if (mode == 3 && got_done) begin
                logic idle_bad;
                idle_bad = 1'b0;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    idle_bad = idle_bad | busy | m_valid | (|rd_en);
                end
                check("start_in_done_ignored", 64'(idle_bad), 64'(0));
            end
            m_ready = 1'b1;
            check("beat_count", 64'(beats), 64'(BEATS));
            check("sb_empty", 64'(exp_q.size()), 64'(0));
`ifdef XDBLE_DRAIN_COPYBACK_EN
            begin
                int bad;
                bad = 0;
                for (int s = 0; s < 4; s++)
                    for (int a = 0; a < W; a++)
                        if (xz[s][a] !== mem_word(s, a)) bad++;
                check("cb_model_bad_words", 64'(bad), 64'(0));
                check("cb_pulses", 64'(cb_pulses), 64'(BEATS));
            end
`else
            check("cb_pulses", 64'(cb_pulses), 64'(0));
`endif
        end
        start = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic drain_w1();
        int nb;
        int lat1;
        nb = 0;
        lat1 = 0;
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (m_valid1) begin
                check("w1_beat", 64'({m_last1, m_sel1, m_data1}), 64'({(nb == 3), 2'(nb), mem_word(nb, 0)}));
                nb++;
            end
            if (done1) begin
                lat1 = k;
                break;
            end
        end
        check("w1_latency", 64'(lat1), 64'(7));
        check("w1_beats", 64'(nb), 64'(4));
    endtask

    initial begin
        int lat;
        n_cmp = 0; n_fail = 0;
        start = 1'b0; start1 = 1'b0; m_ready = 1'b0; m_ready1 = 1'b1;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1 check_all_zero("reset_state");
        check("reset_state_w1", 64'({busy1, done1, rd_en1, m_valid1, m_data1}), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        m_ready = 1'b1;

        drain(0, lat);
        check("latency_ready", 64'(lat), 64'(4 * W + 3));
        @(negedge clk);
        check("busy_after_done", 64'(busy), 64'(0));

        drain(1, lat);
        check("latency_stall", 64'(lat), 64'(4 * W + 3 + 10));
        check("stall_reads_le2", 64'(stall_reads <= 2), 64'(1));

        drain(2, lat);

        drain(3, lat);
        check("latency_restart_ignored", 64'(lat), 64'(4 * W + 3));

        drain(0, lat);
        check("latency_second_start", 64'(lat), 64'(4 * W + 3));

        drain(4, lat);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        drain(0, lat);
        check("latency_after_reset", 64'(lat), 64'(4 * W + 3));

        drain_w1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
